// File: rtl/dvr_stream_checker.sv
// dvr_stream_checker: DVR stream sink used as a bench/BIST endpoint.
// Consumes a programmed number of beats, optionally throttles s_ready with a
// 16-bit LFSR, compares each beat against an incrementing pattern and
// reports error status that stays stable until the next start.
module dvr_stream_checker #(
  parameter int          DATA_WIDTH = 128,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_beats,
  input  logic [DATA_WIDTH-1:0] cfg_first,
  input  logic                  cfg_throttle,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  rcv_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_reg;
  state_t                state_next;

  logic [CNT_WIDTH-1:0]  beats_reg;
  logic                  throttle_reg;
  logic [DATA_WIDTH-1:0] expected_reg;
  logic [15:0]           lfsr_reg;
  logic [15:0]           lfsr_next;
  logic                  ready_int;
  logic                  accept;
  logic                  last_beat;
  logic                  launch;

  // Ready depends only on flops, so there is no path from s_valid to s_ready.
  assign ready_int = (state_reg == ST_RUN) & (~throttle_reg | lfsr_reg[0]);
  assign accept    = s_valid & ready_int;
  assign last_beat = (rcv_count == (beats_reg - CNT_ONE));
  // A start is honoured only while not running.
  assign launch    = start & (state_reg != ST_RUN);

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right with lfsr[0] as output.
  assign lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5],
                      lfsr_reg[15:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (cfg_beats == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        s_ready = ready_int;
        busy    = 1'b1;
        if (accept && last_beat) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = (cfg_beats == '0) ? ST_DONE : ST_RUN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Run configuration and throttle LFSR; the LFSR steps every RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_reg    <= '0;
      throttle_reg <= 1'b0;
      lfsr_reg     <= LFSR_SEED;
    end else if (launch) begin
      beats_reg    <= cfg_beats;
      throttle_reg <= cfg_throttle;
      lfsr_reg     <= LFSR_SEED;
    end else if (state_reg == ST_RUN) begin
      lfsr_reg     <= lfsr_next;
    end
  end

  // Beat counting and pattern check; expected advances even on a mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_reg   <= '0;
      rcv_count      <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else if (launch) begin
      expected_reg   <= cfg_first;
      rcv_count      <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else if (accept) begin
      rcv_count    <= rcv_count + CNT_ONE;
      expected_reg <= expected_reg + DATA_ONE;
      if (s_data != expected_reg) begin
        if (err_count != {CNT_WIDTH{1'b1}}) begin
          err_count <= err_count + CNT_ONE;
        end
        if (err_count == '0) begin
          first_err_idx  <= rcv_count;
          first_err_data <= s_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvr_stream_checker.sv
// Directed testbench for dvr_stream_checker.
module tb_dvr_stream_checker;

  localparam int          DW   = 128;
  localparam int          CW   = 32;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_beats;
  logic [DW-1:0] cfg_first;
  logic          cfg_throttle;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] rcv_count;
  logic [CW-1:0] err_count;
  logic [CW-1:0] first_err_idx;
  logic [DW-1:0] first_err_data;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Results of the most recent drive_run call.
  int run_cycles;
  int run_accepted;
  int run_rdy_bad;

  dvr_stream_checker #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW),
    .LFSR_SEED (SEED)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_beats     (cfg_beats),
    .cfg_first     (cfg_first),
    .cfg_throttle  (cfg_throttle),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .busy          (busy),
    .done          (done),
    .rcv_count     (rcv_count),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .first_err_data(first_err_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11, shift right, bit 0 gates ready.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  // Pulse start for one cycle; returns #1 after the edge that sampled it.
  task automatic do_start(input logic [CW-1:0] beats, input logic [DW-1:0] first,
                          input logic thr);
    cfg_beats    = beats;
    cfg_first    = first;
    cfg_throttle = thr;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Source that keeps valid high and sends first+idx (or bad_val at bad_idx),
  // holding data until accepted. Counts s_ready cycles that differ from the
  // reference LFSR pattern.
  task automatic drive_run(input int n, input logic [DW-1:0] first, input int bad_idx,
                           input logic [DW-1:0] bad_val, input logic thr);
    logic [15:0] ml;
    logic        exp_rdy;
    logic        hs;
    int          idx;
    int          cyc;
    ml  = SEED;
    idx = 0;
    cyc = 0;
    run_rdy_bad = 0;
    while (idx < n && cyc < 2000) begin
      s_valid = 1'b1;
      s_data  = (idx == bad_idx) ? bad_val : first + DW'(idx);
      exp_rdy = ~thr | ml[0];
      if (s_ready !== exp_rdy) run_rdy_bad++;
      hs = s_ready;
      @(posedge clk);
      #1;
      if (hs === 1'b1) begin
        $display("beat %0d data=%0h cycle=%0d", idx, s_data, cyc);
        idx++;
      end
      ml = lfsr_step(ml);
      cyc++;
    end
    s_valid      = 1'b0;
    run_cycles   = cyc;
    run_accepted = idx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    chk_cnt++;
    if ({s_ready, busy, done} !== 3'b000) $display("FAIL reset_ctrl got=%b want=000", {s_ready, busy, done});
    else pass_cnt++;
    chk_cnt++;
    if ({rcv_count, err_count, first_err_idx} !== '0) $display("FAIL reset_counts rcv=%0d err=%0d idx=%0d want=0", rcv_count, err_count, first_err_idx);
    else pass_cnt++;
    chk_cnt++;
    if (first_err_data !== '0) $display("FAIL reset_errdata got=%0h want=0", first_err_data);
    else pass_cnt++;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    // s_valid in IDLE must be ignored
    s_valid = 1'b1;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk_cnt++;
    if (rcv_count !== '0 || s_ready !== 1'b0) $display("FAIL idle_ignore rcv=%0d rdy=%b want=0/0", rcv_count, s_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    do_start(8, DW'(16'h10), 1'b0);
    chk_cnt++;
    if (busy !== 1'b1 || s_ready !== 1'b1) $display("FAIL basic_busy busy=%b rdy=%b want=1/1", busy, s_ready);
    else pass_cnt++;
    drive_run(8, DW'(16'h10), -1, '0, 1'b0);
    chk_cnt++;
    if (run_cycles !== 8) $display("FAIL basic_cycles got=%0d want=8", run_cycles);
    else pass_cnt++;
    chk_cnt++;
    if ({done, busy, s_ready} !== 3'b100) $display("FAIL basic_done got=%b want=100", {done, busy, s_ready});
    else pass_cnt++;
    chk_cnt++;
    if (rcv_count !== 8 || err_count !== 0) $display("FAIL basic_counts rcv=%0d err=%0d want=8/0", rcv_count, err_count);
    else pass_cnt++;
    // Done held and no further beats taken
    s_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk_cnt++;
    if (done !== 1'b1 || rcv_count !== 8) $display("FAIL basic_hold done=%b rcv=%0d want=1/8", done, rcv_count);
    else pass_cnt++;
  endtask

  task automatic test_error();
    do_start(8, DW'(16'h10), 1'b0);
    drive_run(8, DW'(16'h10), 3, DW'(16'hFF), 1'b0);
    chk_cnt++;
    if (err_count !== 1) $display("FAIL err_count got=%0d want=1", err_count);
    else pass_cnt++;
    chk_cnt++;
    if (first_err_idx !== 3) $display("FAIL err_idx got=%0d want=3", first_err_idx);
    else pass_cnt++;
    chk_cnt++;
    if (first_err_data !== DW'(16'hFF)) $display("FAIL err_data got=%0h want=ff", first_err_data);
    else pass_cnt++;
    chk_cnt++;
    if (rcv_count !== 8 || done !== 1'b1) $display("FAIL err_done rcv=%0d done=%b want=8/1", rcv_count, done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Start straight from DONE: status must be cleared for the new run.
    do_start(3, DW'(16'h40), 1'b0);
    chk_cnt++;
    if (err_count !== 0 || first_err_idx !== 0 || first_err_data !== '0 || rcv_count !== 0)
      $display("FAIL b2b_clear err=%0d idx=%0d data=%0h rcv=%0d want=0", err_count, first_err_idx, first_err_data, rcv_count);
    else pass_cnt++;
    drive_run(3, DW'(16'h40), -1, '0, 1'b0);
    chk_cnt++;
    if (rcv_count !== 3 || err_count !== 0 || done !== 1'b1) $display("FAIL b2b_run rcv=%0d err=%0d done=%b want=3/0/1", rcv_count, err_count, done);
    else pass_cnt++;
  endtask

  task automatic test_throttle();
    do_start(100, DW'(16'h200), 1'b1);
    drive_run(100, DW'(16'h200), -1, '0, 1'b1);
    chk_cnt++;
    if (run_rdy_bad !== 0) $display("FAIL thr_pattern bad_cycles=%0d want=0", run_rdy_bad);
    else pass_cnt++;
    chk_cnt++;
    if (run_accepted !== 100 || rcv_count !== 100) $display("FAIL thr_count acc=%0d rcv=%0d want=100", run_accepted, rcv_count);
    else pass_cnt++;
    chk_cnt++;
    if (err_count !== 0 || s_ready !== 1'b0 || done !== 1'b1) $display("FAIL thr_end err=%0d rdy=%b done=%b want=0/0/1", err_count, s_ready, done);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_start(2, {DW{1'b1}}, 1'b0);
    drive_run(2, {DW{1'b1}}, -1, '0, 1'b0);
    chk_cnt++;
    if (err_count !== 0 || rcv_count !== 2) $display("FAIL wrap err=%0d rcv=%0d want=0/2", err_count, rcv_count);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    int rdy_seen;
    do_start(0, '0, 1'b0);
    chk_cnt++;
    if ({done, busy} !== 2'b10) $display("FAIL zero_done got=%b want=10", {done, busy});
    else pass_cnt++;
    rdy_seen = 0;
    s_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (s_ready !== 1'b0) rdy_seen++;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    chk_cnt++;
    if (rdy_seen !== 0 || rcv_count !== 0) $display("FAIL zero_idle rdy_cycles=%0d rcv=%0d want=0/0", rdy_seen, rcv_count);
    else pass_cnt++;
  endtask

  task automatic test_midrun_reset();
    do_start(20, DW'(16'h5), 1'b0);
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = DW'(16'h5) + DW'(i);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    chk_cnt++;
    if (rcv_count !== 5) $display("FAIL mid_pre rcv=%0d want=5", rcv_count);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({s_ready, busy, done} !== 3'b000 || rcv_count !== 0) $display("FAIL mid_async ctrl=%b rcv=%0d want=000/0", {s_ready, busy, done}, rcv_count);
    else pass_cnt++;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    do_start(10, DW'(16'h77), 1'b1);
    drive_run(10, DW'(16'h77), -1, '0, 1'b1);
    chk_cnt++;
    if (run_rdy_bad !== 0 || rcv_count !== 10 || err_count !== 0) $display("FAIL mid_restart badrdy=%0d rcv=%0d err=%0d want=0/10/0", run_rdy_bad, rcv_count, err_count);
    else pass_cnt++;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    cfg_beats    = '0;
    cfg_first    = '0;
    cfg_throttle = 1'b0;
    s_data       = '0;
    s_valid      = 1'b0;
    test_reset();
    test_basic();
    test_error();
    test_back_to_back();
    test_throttle();
    test_wrap();
    test_zero();
    test_midrun_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
